nes_timing_gen: RTL

//  Master-clock timing generator directly upstream of CPU, DmaController, APU and PPU in the NES top.

---
 rtl/nes_timing_pkg.sv | 42 ++++
 rtl/nes_mod_counter.sv | 42 ++++
 rtl/nes_timing_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/nes_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Package : nes_timing_pkg
//  Brief   : Region codes and per-region divisor tables for the NES master
//            clock timing generator.
//  Rev     : 1.0  initial release
// ============================================================================
package nes_timing_pkg;

  localparam logic [1:0] SYS_NTSC  = 2'd0;
  localparam logic [1:0] SYS_PAL   = 2'd1;
  localparam logic [1:0] SYS_DENDY = 2'd2;

  // Master clocks per CPU cycle; code 3 falls back to NTSC timing.
  function automatic logic [4:0] cpu_div_of(input logic [1:0] sys);
    case (sys)
      SYS_PAL:   return 5'd16;
      SYS_DENDY: return 5'd15;
      default:   return 5'd12;
    endcase
  endfunction

  // Master clocks per PPU dot.
  function automatic logic [4:0] ppu_div_of(input logic [1:0] sys);
    case (sys)
      SYS_PAL:   return 5'd5;
      SYS_DENDY: return 5'd5;
      default:   return 5'd4;
    endcase
  endfunction

  // First cpu_div value at which M2 is high.
  function automatic logic [4:0] phi2_rise_of(input logic [1:0] sys);
    case (sys)
      SYS_PAL:   return 5'd6;
      SYS_DENDY: return 5'd6;
      default:   return 5'd5;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/nes_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module  : nes_mod_counter
//  Brief   : 5-bit modulo counter with enable, synchronous load (priority)
//            and a terminal-count flag computed on the next-state value.
//  Rev     : 1.0  initial release
// ============================================================================
module nes_mod_counter
  import nes_timing_pkg::*;
(
  input  logic       clk,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [4:0] i_load_val,
  input  logic [4:0] i_mod,       // modulus that applies to the next state
  output logic [4:0] o_cnt,
  output logic       o_tc_next    // next state equals i_mod-1
);

  logic [4:0] r_cnt;
  logic [4:0] w_next;

  // Next-state: load wins, otherwise count and wrap at i_mod-1.
  always_comb begin
    w_next = r_cnt;
    if (i_load) begin
      w_next = i_load_val;
    end else if (i_en) begin
      w_next = (r_cnt >= i_mod - 5'd1) ? 5'd0 : r_cnt + 5'd1;
    end
  end

  // Counter state; initialisation comes through the synchronous load.
  always_ff @(posedge clk) begin
    r_cnt <= w_next;
  end

  assign o_cnt     = r_cnt;
  assign o_tc_next = (w_next == i_mod - 5'd1);

endmodule
`default_nettype wire

// File: rtl/nes_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module  : nes_timing_gen
//  Brief   : NES master-clock timing generator. Emits CPU/APU/PPU clock
//            enables, the M2 level, APU odd/even phase and PPU sub-slot index.
//            Region changes take effect only where both dividers wrap.
//  Rev     : 1.0  initial release
// ============================================================================
module nes_timing_gen
  import nes_timing_pkg::*;
#(
  parameter int PPU_PHASE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sys_type,
  input  logic       pause,
  output logic       cpu_ce,
  output logic       apu_ce,
  output logic       ppu_ce,
  output logic       phi2,
  output logic       odd_or_even,
  output logic [1:0] ppu_sub,
  output logic [1:0] sys_active
);

  // Reset-time PPU phase, already reduced for both possible PPU divisors.
  localparam logic [4:0] c_phase_mod4 = 5'(PPU_PHASE % 4);
  localparam logic [4:0] c_phase_mod5 = 5'(PPU_PHASE % 5);

  logic [1:0] r_sys_active;
  logic       r_cpu_ce;
  logic       r_apu_ce;
  logic       r_ppu_ce;
  logic       r_phi2;
  logic       r_odd;
  logic [1:0] r_sub;

  logic [4:0] w_cpu_cnt;
  logic [4:0] w_ppu_cnt;
  logic       w_cpu_tc_next;
  logic       w_ppu_tc_next;
  logic [4:0] w_cur_cdiv;
  logic [4:0] w_cur_pdiv;
  logic [4:0] w_cur_rise;
  logic       w_boundary;
  logic       w_switch;
  logic       w_load;
  logic [1:0] w_region_next;
  logic [4:0] w_cdiv_next;
  logic [4:0] w_pdiv_next;
  logic [4:0] w_ppu_load_val;

  assign w_cur_cdiv = cpu_div_of(r_sys_active);
  assign w_cur_pdiv = ppu_div_of(r_sys_active);
  assign w_cur_rise = phi2_rise_of(r_sys_active);

  // Both dividers sit on their last count: the only legal place to retime.
  assign w_boundary = (w_cpu_cnt == w_cur_cdiv - 5'd1) &&
                      (w_ppu_cnt == w_cur_pdiv - 5'd1);
  assign w_switch   = !reset && !pause && w_boundary && (sys_type != r_sys_active);

  assign w_load        = reset || w_switch;
  assign w_region_next = w_load ? sys_type : r_sys_active;
  assign w_cdiv_next   = cpu_div_of(w_region_next);
  assign w_pdiv_next   = ppu_div_of(w_region_next);

  // Phase trim only on reset; a region switch restarts both dividers at 0.
  assign w_ppu_load_val = !reset ? 5'd0 :
                          (ppu_div_of(sys_type) == 5'd4) ? c_phase_mod4 : c_phase_mod5;

  nes_mod_counter u_cpu_cnt (
    .clk        (clk),
    .i_en       (!pause),
    .i_load     (w_load),
    .i_load_val (5'd0),
    .i_mod      (w_cdiv_next),
    .o_cnt      (w_cpu_cnt),
    .o_tc_next  (w_cpu_tc_next)
  );

  nes_mod_counter u_ppu_cnt (
    .clk        (clk),
    .i_en       (!pause),
    .i_load     (w_load),
    .i_load_val (w_ppu_load_val),
    .i_mod      (w_pdiv_next),
    .o_cnt      (w_ppu_cnt),
    .o_tc_next  (w_ppu_tc_next)
  );

  // Output flops decoded from the counters' next state; odd/even and ppu_sub
  // react to the pulse currently on the outputs, so a pulse shown just before
  // a pause is still accounted exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sys_active <= sys_type;
      r_cpu_ce     <= 1'b0;
      r_apu_ce     <= 1'b0;
      r_ppu_ce     <= 1'b0;
      r_phi2       <= 1'b0;
      r_odd        <= 1'b0;
      r_sub        <= 2'd0;
    end else begin
      r_sys_active <= w_region_next;
      r_cpu_ce     <= !pause && w_cpu_tc_next;
      r_apu_ce     <= !pause && w_cpu_tc_next;
      r_ppu_ce     <= !pause && w_ppu_tc_next;
      // M2 is high once the next cpu_div reaches the rise point; it drops as
      // the divider wraps (which also covers a region switch).
      if (!pause) begin
        r_phi2 <= (w_cpu_cnt >= w_cur_rise - 5'd1) && (w_cpu_cnt != w_cur_cdiv - 5'd1);
      end
      r_odd <= r_odd ^ r_cpu_ce;
      if (r_cpu_ce) begin
        r_sub <= 2'd0;
      end else if (r_ppu_ce && (r_sub != 2'd3)) begin
        r_sub <= r_sub + 2'd1;
      end
    end
  end

  assign cpu_ce      = r_cpu_ce;
  assign apu_ce      = r_apu_ce;
  assign ppu_ce      = r_ppu_ce;
  assign phi2        = r_phi2;
  assign odd_or_even = r_odd;
  assign ppu_sub     = r_sub;
  assign sys_active  = r_sys_active;

endmodule
`default_nettype wire
